// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// shift-add multiplier; one result register shared by all operations.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             z_flag,
  output logic             n_flag,
  output logic             c_flag,
  output logic             v_flag,
  output logic             err
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t             state_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   out_reg;
  logic               z_reg;
  logic               n_reg;
  logic               c_reg;
  logic               v_reg;
  logic               err_reg;
  logic [WIDTH-1:0]   mul_acc_reg;
  logic [WIDTH-1:0]   mul_mcand_reg;
  logic [WIDTH-1:0]   mul_mplier_reg;
  logic [SHAMT_W-1:0] mul_cnt_reg;

  logic [WIDTH-1:0]   alu_res_next;
  logic               alu_c_next;
  logic               alu_v_next;
  logic               alu_err_next;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     dif_ext;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   mul_sum;
  logic               mul_last;
  logic               accept;

  // A new request may enter only when idle and the result slot is free or draining now.
  assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  assign shamt    = in2[SHAMT_W-1:0];
  assign sum_ext  = {1'b0, in1} + {1'b0, in2};
  assign dif_ext  = {1'b0, in1} + {1'b0, ~in2} + {{WIDTH{1'b0}}, 1'b1};
  assign mul_sum  = mul_acc_reg + (mul_mplier_reg[0] ? mul_mcand_reg : {WIDTH{1'b0}});
  assign mul_last = (mul_cnt_reg == SHAMT_W'(WIDTH - 1));

  always_comb begin
    alu_res_next = '0;
    alu_c_next   = 1'b0;
    alu_v_next   = 1'b0;
    alu_err_next = 1'b0;
    case (func)
      OP_ADD: begin
        alu_res_next = sum_ext[WIDTH-1:0];
        alu_c_next   = sum_ext[WIDTH];
        alu_v_next   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_ext[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_next = dif_ext[WIDTH-1:0];
        alu_c_next   = dif_ext[WIDTH];
        alu_v_next   = (in1[WIDTH-1] != in2[WIDTH-1]) && (dif_ext[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SLL:  alu_res_next = in1 << shamt;
      OP_SRL:  alu_res_next = in1 >> shamt;
      OP_SRA:  alu_res_next = $signed(in1) >>> shamt;
      OP_OR:   alu_res_next = in1 | in2;
      OP_AND:  alu_res_next = in1 & in2;
      OP_XOR:  alu_res_next = in1 ^ in2;
      OP_SLT:  alu_res_next = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU: alu_res_next = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_MUL:  alu_res_next = '0;
      default: alu_err_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      out_valid_reg  <= 1'b0;
      out_reg        <= '0;
      z_reg          <= 1'b0;
      n_reg          <= 1'b0;
      c_reg          <= 1'b0;
      v_reg          <= 1'b0;
      err_reg        <= 1'b0;
      mul_acc_reg    <= '0;
      mul_mcand_reg  <= '0;
      mul_mplier_reg <= '0;
      mul_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (out_valid_reg && out_ready)
            out_valid_reg <= 1'b0;
          if (accept) begin
            if (func == OP_MUL) begin
              state_reg      <= MUL_BUSY;
              mul_acc_reg    <= '0;
              mul_mcand_reg  <= in1;
              mul_mplier_reg <= in2;
              mul_cnt_reg    <= '0;
            end else begin
              out_reg       <= alu_res_next;
              z_reg         <= (alu_res_next == '0);
              n_reg         <= alu_res_next[WIDTH-1];
              c_reg         <= alu_c_next;
              v_reg         <= alu_v_next;
              err_reg       <= alu_err_next;
              out_valid_reg <= 1'b1;
            end
          end
        end
        MUL_BUSY: begin
          // One multiplier bit per cycle; the final partial sum goes straight to the output.
          mul_acc_reg    <= mul_sum;
          mul_mcand_reg  <= mul_mcand_reg << 1;
          mul_mplier_reg <= mul_mplier_reg >> 1;
          mul_cnt_reg    <= mul_cnt_reg + 1'b1;
          if (mul_last) begin
            out_reg       <= mul_sum;
            z_reg         <= (mul_sum == '0);
            n_reg         <= mul_sum[WIDTH-1];
            c_reg         <= 1'b0;
            v_reg         <= 1'b0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign z_flag    = z_reg;
  assign n_flag    = n_reg;
  assign c_flag    = c_reg;
  assign v_flag    = v_reg;
  assign err       = err_reg;

endmodule
